// File: rtl/csr_master_initiator.sv
// Single-outstanding CSR bus initiator: takes one client read/write, drives the
// pipelined CSR request, waits for acknowledge/read data, then reports completion.
module csr_master_initiator (
  input  logic        clk,
  input  logic        clk__enable,
  input  logic        reset,
  input  logic [15:0] master_timeout,
  input  logic        user_request__valid,
  input  logic        user_request__read_not_write,
  input  logic [15:0] user_request__select,
  input  logic [15:0] user_request__address,
  input  logic [31:0] user_request__data,
  output logic        user_ready,
  output logic        user_response__valid,
  output logic        user_response__error,
  output logic [31:0] user_response__read_data,
  output logic        csr_request__valid,
  output logic        csr_request__read_not_write,
  output logic [15:0] csr_request__select,
  output logic [15:0] csr_request__address,
  output logic [31:0] csr_request__data,
  input  logic        csr_response__acknowledge,
  input  logic        csr_response__read_data_valid,
  input  logic        csr_response__read_data_error,
  input  logic [31:0] csr_response__read_data
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQUEST   = 2'd1,
    ST_READ_WAIT = 2'd2,
    ST_COMPLETE  = 2'd3
  } state_t;

  state_t      r_state, w_state_nxt;

  logic        r_ready, w_ready_nxt;
  logic        r_resp_vld, w_resp_vld_nxt;
  logic        r_resp_err, w_resp_err_nxt;
  logic [31:0] r_resp_data, w_resp_data_nxt;
  logic        r_csr_vld, w_csr_vld_nxt;
  logic        r_csr_rnw, w_csr_rnw_nxt;
  logic [15:0] r_csr_sel, w_csr_sel_nxt;
  logic [15:0] r_csr_addr, w_csr_addr_nxt;
  logic [31:0] r_csr_data, w_csr_data_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;

  // A counter loaded with 0 never reaches 1, so a zero timeout waits forever
  // without looking at the live master_timeout input.
  logic        w_expire;
  assign w_expire = (r_cnt == 16'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else if (clk__enable) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (user_request__valid) w_state_nxt = ST_REQUEST;
      end
      ST_REQUEST: begin
        if (csr_response__acknowledge)
          w_state_nxt = r_csr_rnw ? ST_READ_WAIT : ST_COMPLETE;
        else if (w_expire)
          w_state_nxt = ST_COMPLETE;
      end
      ST_READ_WAIT: begin
        if (csr_response__read_data_valid || w_expire) w_state_nxt = ST_COMPLETE;
      end
      ST_COMPLETE: w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_ready_nxt     = r_ready;
    w_resp_vld_nxt  = r_resp_vld;
    w_resp_err_nxt  = r_resp_err;
    w_resp_data_nxt = r_resp_data;
    w_csr_vld_nxt   = r_csr_vld;
    w_csr_rnw_nxt   = r_csr_rnw;
    w_csr_sel_nxt   = r_csr_sel;
    w_csr_addr_nxt  = r_csr_addr;
    w_csr_data_nxt  = r_csr_data;
    w_cnt_nxt       = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (user_request__valid) begin
          w_csr_vld_nxt  = 1'b1;
          w_csr_rnw_nxt  = user_request__read_not_write;
          w_csr_sel_nxt  = user_request__select;
          w_csr_addr_nxt = user_request__address;
          w_csr_data_nxt = user_request__data;
          w_ready_nxt    = 1'b0;
          w_cnt_nxt      = master_timeout;
        end
      end
      ST_REQUEST: begin
        // Acknowledge takes priority over a simultaneous timeout expiry.
        if (csr_response__acknowledge) begin
          w_csr_vld_nxt = 1'b0;
          w_cnt_nxt     = master_timeout;
          if (!r_csr_rnw) begin
            w_resp_vld_nxt  = 1'b1;
            w_resp_err_nxt  = 1'b0;
            w_resp_data_nxt = 32'd0;
          end
        end else if (w_expire) begin
          w_csr_vld_nxt   = 1'b0;
          w_resp_vld_nxt  = 1'b1;
          w_resp_err_nxt  = 1'b1;
          w_resp_data_nxt = 32'd0;
        end else if (r_cnt != 16'd0) begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      ST_READ_WAIT: begin
        if (csr_response__read_data_valid) begin
          w_resp_vld_nxt  = 1'b1;
          w_resp_err_nxt  = csr_response__read_data_error;
          w_resp_data_nxt = csr_response__read_data;
        end else if (w_expire) begin
          w_resp_vld_nxt  = 1'b1;
          w_resp_err_nxt  = 1'b1;
          w_resp_data_nxt = 32'd0;
        end else if (r_cnt != 16'd0) begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      ST_COMPLETE: begin
        w_resp_vld_nxt  = 1'b0;
        w_resp_err_nxt  = 1'b0;
        w_resp_data_nxt = 32'd0;
        w_ready_nxt     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ready     <= 1'b1;
      r_resp_vld  <= 1'b0;
      r_resp_err  <= 1'b0;
      r_resp_data <= 32'd0;
      r_csr_vld   <= 1'b0;
      r_csr_rnw   <= 1'b0;
      r_csr_sel   <= 16'd0;
      r_csr_addr  <= 16'd0;
      r_csr_data  <= 32'd0;
      r_cnt       <= 16'd0;
    end else if (clk__enable) begin
      r_ready     <= w_ready_nxt;
      r_resp_vld  <= w_resp_vld_nxt;
      r_resp_err  <= w_resp_err_nxt;
      r_resp_data <= w_resp_data_nxt;
      r_csr_vld   <= w_csr_vld_nxt;
      r_csr_rnw   <= w_csr_rnw_nxt;
      r_csr_sel   <= w_csr_sel_nxt;
      r_csr_addr  <= w_csr_addr_nxt;
      r_csr_data  <= w_csr_data_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  assign user_ready                  = r_ready;
  assign user_response__valid        = r_resp_vld;
  assign user_response__error        = r_resp_err;
  assign user_response__read_data    = r_resp_data;
  assign csr_request__valid          = r_csr_vld;
  assign csr_request__read_not_write = r_csr_rnw;
  assign csr_request__select         = r_csr_sel;
  assign csr_request__address        = r_csr_addr;
  assign csr_request__data           = r_csr_data;

endmodule

// File: tb/tb_csr_master_initiator.sv
// Directed bench for csr_master_initiator: the stimulus process acts as client and
// target and queues expected completions; a monitor checks each response pulse.
module tb_csr_master_initiator;

  logic        clk = 1'b0;
  logic        clk__enable;
  logic        reset;
  logic [15:0] master_timeout;
  logic        user_request__valid;
  logic        user_request__read_not_write;
  logic [15:0] user_request__select;
  logic [15:0] user_request__address;
  logic [31:0] user_request__data;
  logic        user_ready;
  logic        user_response__valid;
  logic        user_response__error;
  logic [31:0] user_response__read_data;
  logic        csr_request__valid;
  logic        csr_request__read_not_write;
  logic [15:0] csr_request__select;
  logic [15:0] csr_request__address;
  logic [31:0] csr_request__data;
  logic        csr_response__acknowledge;
  logic        csr_response__read_data_valid;
  logic        csr_response__read_data_error;
  logic [31:0] csr_response__read_data;

  csr_master_initiator dut (
    .clk                           (clk),
    .clk__enable                   (clk__enable),
    .reset                         (reset),
    .master_timeout                (master_timeout),
    .user_request__valid           (user_request__valid),
    .user_request__read_not_write  (user_request__read_not_write),
    .user_request__select          (user_request__select),
    .user_request__address         (user_request__address),
    .user_request__data            (user_request__data),
    .user_ready                    (user_ready),
    .user_response__valid          (user_response__valid),
    .user_response__error          (user_response__error),
    .user_response__read_data      (user_response__read_data),
    .csr_request__valid            (csr_request__valid),
    .csr_request__read_not_write   (csr_request__read_not_write),
    .csr_request__select           (csr_request__select),
    .csr_request__address          (csr_request__address),
    .csr_request__data             (csr_request__data),
    .csr_response__acknowledge     (csr_response__acknowledge),
    .csr_response__read_data_valid (csr_response__read_data_valid),
    .csr_response__read_data_error (csr_response__read_data_error),
    .csr_response__read_data       (csr_response__read_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every response pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (user_response__valid === 1'b1) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_response: got valid err=%b data=%h expected none (cycle %0d)",
                 user_response__error, user_response__read_data, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("resp_error", {31'd0, user_response__error}, {31'd0, e.err});
        chk("resp_data", user_response__read_data, e.data);
        chk("resp_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push(input logic err, input logic [31:0] data, input int c);
    exp_t e;
    e.err  = err;
    e.data = data;
    e.cyc  = c;
    q.push_back(e);
  endtask

  // Called at a negedge with the DUT idle; returns the acceptance cycle.
  task automatic issue(input logic rnw, input logic [15:0] sel, input logic [15:0] addr,
                       input logic [31:0] data, output int t0);
    chk("ready_before_issue", {31'd0, user_ready}, 32'd1);
    t0 = cyc;
    user_request__valid          = 1'b1;
    user_request__read_not_write = rnw;
    user_request__select         = sel;
    user_request__address        = addr;
    user_request__data           = data;
    @(negedge clk);
    user_request__valid = 1'b0;
  endtask

  initial begin
    int t0;
    int t1;
    clk__enable = 1'b1;
    reset = 1'b1;
    master_timeout = 16'd0;
    user_request__valid = 1'b0;
    user_request__read_not_write = 1'b0;
    user_request__select = 16'd0;
    user_request__address = 16'd0;
    user_request__data = 32'd0;
    csr_response__acknowledge = 1'b0;
    csr_response__read_data_valid = 1'b0;
    csr_response__read_data_error = 1'b0;
    csr_response__read_data = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, user_ready}, 32'd1);
    chk("rst_csr_valid", {31'd0, csr_request__valid}, 32'd0);
    chk("rst_resp_valid", {31'd0, user_response__valid}, 32'd0);
    chk("rst_resp_data", user_response__read_data, 32'd0);
    chk("rst_csr_data", csr_request__data, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Write, ack in cycle 3
    issue(1'b0, 16'h0002, 16'h0010, 32'hDEADBEEF, t0);
    push(1'b0, 32'd0, t0 + 4);
    chk("w_csr_valid_c1", {31'd0, csr_request__valid}, 32'd1);
    chk("w_csr_rnw", {31'd0, csr_request__read_not_write}, 32'd0);
    chk("w_csr_sel", {16'd0, csr_request__select}, 32'h0002);
    chk("w_csr_addr", {16'd0, csr_request__address}, 32'h0010);
    chk("w_csr_data", csr_request__data, 32'hDEADBEEF);
    goto(t0 + 3);
    chk("w_csr_valid_c3", {31'd0, csr_request__valid}, 32'd1);
    csr_response__acknowledge = 1'b1;
    goto(t0 + 4);
    csr_response__acknowledge = 1'b0;
    chk("w_csr_valid_c4", {31'd0, csr_request__valid}, 32'd0);
    chk("w_ready_c4", {31'd0, user_ready}, 32'd0);
    goto(t0 + 5);
    chk("w_ready_c5", {31'd0, user_ready}, 32'd1);

    // Read; stray read_data_valid during REQUEST must be ignored
    issue(1'b1, 16'h0001, 16'h0020, 32'd0, t0);
    push(1'b0, 32'h12345678, t0 + 4);
    csr_response__read_data_valid = 1'b1;
    csr_response__read_data = 32'h00000BAD;
    goto(t0 + 2);
    csr_response__read_data_valid = 1'b0;
    csr_response__read_data = 32'd0;
    csr_response__acknowledge = 1'b1;
    goto(t0 + 3);
    csr_response__acknowledge = 1'b0;
    csr_response__read_data_valid = 1'b1;
    csr_response__read_data = 32'h12345678;
    goto(t0 + 4);
    csr_response__read_data_valid = 1'b0;
    csr_response__read_data = 32'd0;
    chk("r_ready_c4", {31'd0, user_ready}, 32'd0);
    goto(t0 + 5);
    chk("r_ready_c5", {31'd0, user_ready}, 32'd1);
    chk("r_data_cleared", user_response__read_data, 32'd0);

    // Read against a timeout-style target (error, data 0)
    issue(1'b1, 16'h8000, 16'h0004, 32'd0, t0);
    push(1'b1, 32'd0, t0 + 3);
    csr_response__acknowledge = 1'b1;
    goto(t0 + 2);
    csr_response__acknowledge = 1'b0;
    csr_response__read_data_valid = 1'b1;
    csr_response__read_data_error = 1'b1;
    goto(t0 + 3);
    csr_response__read_data_valid = 1'b0;
    csr_response__read_data_error = 1'b0;
    goto(t0 + 5);

    // Master timeout 4, no target; timeout input changed mid-flight is not resampled
    master_timeout = 16'd4;
    issue(1'b0, 16'h0003, 16'h0030, 32'h11111111, t0);
    push(1'b1, 32'd0, t0 + 5);
    goto(t0 + 2);
    master_timeout = 16'd0;
    goto(t0 + 4);
    chk("to_csr_valid_c4", {31'd0, csr_request__valid}, 32'd1);
    goto(t0 + 5);
    chk("to_csr_valid_c5", {31'd0, csr_request__valid}, 32'd0);
    goto(t0 + 7);

    // Timeout disabled: 1000 cycles of silence, then a late ack completes normally
    master_timeout = 16'd0;
    issue(1'b0, 16'h0004, 16'h0040, 32'h22222222, t0);
    goto(t0 + 1000);
    chk("inf_csr_valid", {31'd0, csr_request__valid}, 32'd1);
    chk("inf_ready", {31'd0, user_ready}, 32'd0);
    csr_response__acknowledge = 1'b1;
    push(1'b0, 32'd0, t0 + 1001);
    goto(t0 + 1001);
    csr_response__acknowledge = 1'b0;
    goto(t0 + 1003);

    // Ack coincident with counter==1 wins over the abort
    master_timeout = 16'd3;
    issue(1'b0, 16'h0005, 16'h0050, 32'h33333333, t0);
    push(1'b0, 32'd0, t0 + 4);
    goto(t0 + 3);
    csr_response__acknowledge = 1'b1;
    goto(t0 + 4);
    csr_response__acknowledge = 1'b0;
    goto(t0 + 6);

    // Read-phase timeout: T=2, READ_WAIT entered in cycle 2
    master_timeout = 16'd2;
    issue(1'b1, 16'h0006, 16'h0060, 32'd0, t0);
    push(1'b1, 32'd0, t0 + 4);
    csr_response__acknowledge = 1'b1;
    goto(t0 + 2);
    csr_response__acknowledge = 1'b0;
    goto(t0 + 6);

    // Timeout 1: abort after a single silent cycle
    master_timeout = 16'd1;
    issue(1'b0, 16'h0007, 16'h0070, 32'h44444444, t0);
    push(1'b1, 32'd0, t0 + 2);
    goto(t0 + 2);
    chk("t1_csr_valid_c2", {31'd0, csr_request__valid}, 32'd0);
    goto(t0 + 4);

    // Asynchronous reset mid-REQUEST: no response
    master_timeout = 16'd0;
    issue(1'b0, 16'h0008, 16'h0080, 32'h55555555, t0);
    goto(t0 + 2);
    #2 reset = 1'b1;
    #1;
    chk("arst_csr_valid", {31'd0, csr_request__valid}, 32'd0);
    chk("arst_ready", {31'd0, user_ready}, 32'd1);
    chk("arst_csr_sel", {16'd0, csr_request__select}, 32'd0);
    chk("arst_resp_valid", {31'd0, user_response__valid}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_ready", {31'd0, user_ready}, 32'd1);

    // Clock enable low for 5 cycles in READ_WAIT; read data offered meanwhile is ignored
    issue(1'b1, 16'h0009, 16'h0090, 32'd0, t0);
    push(1'b0, 32'hCAFEF00D, t0 + 8);
    csr_response__acknowledge = 1'b1;
    goto(t0 + 2);
    csr_response__acknowledge = 1'b0;
    clk__enable = 1'b0;
    goto(t0 + 4);
    csr_response__read_data_valid = 1'b1;
    csr_response__read_data = 32'h0BADBEEF;
    goto(t0 + 5);
    csr_response__read_data_valid = 1'b0;
    csr_response__read_data = 32'd0;
    chk("ce_ready_frozen", {31'd0, user_ready}, 32'd0);
    chk("ce_csr_valid_frozen", {31'd0, csr_request__valid}, 32'd0);
    goto(t0 + 7);
    clk__enable = 1'b1;
    csr_response__read_data_valid = 1'b1;
    csr_response__read_data = 32'hCAFEF00D;
    goto(t0 + 8);
    csr_response__read_data_valid = 1'b0;
    csr_response__read_data = 32'd0;
    goto(t0 + 10);

    // Requests while busy are ignored; then back-to-back transaction
    issue(1'b0, 16'h000A, 16'h00A0, 32'h66666666, t0);
    push(1'b0, 32'd0, t0 + 4);
    user_request__valid = 1'b1;
    user_request__read_not_write = 1'b1;
    user_request__select = 16'hAAAA;
    user_request__address = 16'hBBBB;
    user_request__data = 32'hCCCCCCCC;
    goto(t0 + 2);
    chk("busy_csr_sel", {16'd0, csr_request__select}, 32'h000A);
    chk("busy_csr_rnw", {31'd0, csr_request__read_not_write}, 32'd0);
    goto(t0 + 3);
    user_request__valid = 1'b0;
    csr_response__acknowledge = 1'b1;
    goto(t0 + 4);
    csr_response__acknowledge = 1'b0;
    chk("b2b_gap_c4", {31'd0, csr_request__valid}, 32'd0);
    goto(t0 + 5);
    chk("b2b_gap_c5", {31'd0, csr_request__valid}, 32'd0);
    issue(1'b0, 16'h000B, 16'h00B0, 32'h77777777, t1);
    chk("b2b_t1", t1, t0 + 5);
    push(1'b0, 32'd0, t1 + 2);
    chk("b2b_csr_addr", {16'd0, csr_request__address}, 32'h00B0);
    csr_response__acknowledge = 1'b1;
    goto(t1 + 2);
    csr_response__acknowledge = 1'b0;
    goto(t1 + 6);

    chk("pending_responses", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/csr_master_initiator.md
# csr_master_initiator

Single-outstanding CSR initiator: accepts one read or write at a time from a simple client port. It drives it onto the pipelined CSR request bus, waits for a target's acknowledge, and for reads collects the returned data. It then reports completion to the client. It sits at the master end of the CSR bus, above the targets (including the timeout target), whose responses are OR-combined onto its `csr_response` inputs. An optional master-side timeout aborts transactions that no target ever answers.

## Interface
Parameters: none.

- `clk` in 1: CSR clock.
- `clk__enable` in 1: clock enable; when low all state holds.
- `reset` in 1: asynchronous, active-high reset.
- `master_timeout` in 16: cycles to wait per phase before aborting; 0 disables the master timeout.
- `user_request__valid` in 1: client request strobe; sampled only when `user_ready`=1.
- `user_request__read_not_write` in 1: 1 = read, 0 = write.
- `user_request__select` in 16: target select.
- `user_request__address` in 16: register address.
- `user_request__data` in 32: write data.
- `user_ready` out 1: module idle, can accept a request.
- `user_response__valid` out 1: one-cycle completion pulse.
- `user_response__error` out 1: set with valid on master timeout or target read error.
- `user_response__read_data` out 32: read data, qualified by valid; 0 for writes, errors and aborts.
- `csr_request__valid` out 1: CSR request valid.
- `csr_request__read_not_write` out 1: CSR request direction.
- `csr_request__select` out 16: CSR request select.
- `csr_request__address` out 16: CSR request address.
- `csr_request__data` out 32: CSR request write data.
- `csr_response__acknowledge` in 1: OR of target acknowledges.
- `csr_response__read_data_valid` in 1: OR of target read-data valids.
- `csr_response__read_data_error` in 1: OR of target read-data errors.
- `csr_response__read_data` in 32: OR of target read data.

## Operation
All outputs are registered. The FSM has four states: IDLE, REQUEST, READ_WAIT, COMPLETE. The phase counter is 16 bits.

Reset values:
- FSM in IDLE, counter 0.
- `user_ready`=1; all other outputs 0, including all `csr_request__*` and all `user_response__*`.

IDLE:
- On `user_request__valid`, capture all request fields into the `csr_request__*` registers.
- Set `csr_request__valid`=1 and `user_ready`=0.
- Load counter with `master_timeout`; go to REQUEST.

REQUEST:
- `csr_request__*` are held stable.
- **Ack seen:** `csr_request__valid`←0 and counter reloads `master_timeout`.
  - Write: go to COMPLETE with error=0, data=0.
  - Read: go to READ_WAIT.
- **No ack, `master_timeout`≠0:**
  - Counter==1: abort. `csr_request__valid`←0; go to COMPLETE with error=1, data=0.
  - Otherwise the counter decrements.
- `read_data_valid` is ignored in this state.

READ_WAIT:
- **`read_data_valid` seen:** capture `read_data` and `read_data_error` into `user_response__*`; go to COMPLETE.
- **Otherwise:** apply the same counter and abort rule as REQUEST (error=1, data=0).
- `acknowledge` is ignored in this state.

COMPLETE:
- `user_response__valid`=1 for exactly one cycle.
- Next cycle: return to IDLE; `user_response__valid`←0, `user_ready`←1, `user_response__read_data`←0.

Boundary rules:
- Ack and timeout expiry in the same cycle: ack wins.
- `master_timeout`=0: wait forever.
- `master_timeout`=1: abort after one cycle without response.
- `master_timeout` is sampled only at load points.
- Client requests while `user_ready`=0 are ignored; the client must hold or re-present them.
- Reset mid-transaction drops `csr_request__valid` immediately (asynchronous). No response is generated.

## Timing
Let cycle 0 be the cycle in which a request is accepted (`user_request__valid` && `user_ready`).

- `csr_request__valid` is high from cycle 1.
- If ack is first high in cycle N (N≥1):
  - `csr_request__valid` is low from N+1.
  - Write: `user_response__valid` is high in N+1 and `user_ready` returns in N+2.
- For a read, with `read_data_valid` in cycle M (M≥N+1):
  - `user_response__valid` is high in M+1.
  - `user_ready` returns in M+2.
- Minimum occupancy is 3 cycles for a write and 4 for a read.
- Back-to-back requests: `csr_request__valid` is low for at least 2 cycles between transactions.
- Abort with `master_timeout`=T:
  - Request phase: response valid at cycle T+1.
  - Read phase: response valid T cycles after the read phase is entered.

## Test plan
- **Write, ack at cycle 3:** request write sel=0x0002 addr=0x0010 data=0xDEADBEEF, ack in cycle 3 → csr valid in cycles 1–3; `user_response__valid` in cycle 4 with error=0, data=0; `user_ready` in cycle 5.
- **Read, normal completion:** request read, ack in cycle 2, `read_data_valid` in cycle 3 with data 0x12345678, error 0 → response in cycle 4 with data 0x12345678, error=0.
- **Read against a timeout-style target:** ack then `read_data_valid` with error=1, data=0 → response with error=1, data=0.
- **Master timeout, no target:** `master_timeout`=4, no ack → csr valid in cycles 1–4, low in cycle 5; response error=1 in cycle 5.
  - Repeat with `master_timeout`=0 held for 1000 cycles → no response; a late ack then completes normally.
- **Ack at expiry:** ack coincident with counter==1 → normal completion, error=0.
- **Misc:**
  - Assert `reset` mid-REQUEST → all outputs at reset values, no response pulse.
  - `clk__enable` low for 5 cycles mid-READ_WAIT → state and outputs frozen, then resume.
  - Requests presented while busy → ignored.
